// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding, index-width helper and saturation bounds for the Conv2d result path
package conv_pkg;
  typedef enum logic {IDLE, STREAM} state_t;
  function automatic int idxW(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int satMax(input int bw);
    return (1 << (bw - 1)) - 1;
  endfunction
  function automatic int satMin(input int bw);
    return -(1 << (bw - 1));
  endfunction
endpackage

// File: rtl/conv2d_result_streamer_if.sv
// conv2d_result_streamer_if: result-bus capture handshake plus per-element output stream
interface conv2d_result_streamer_if #(
  parameter int BITWIDTH = 8,
  parameter int OUTWIDTH = 2,
  parameter int OUTHEIGHT = 2,
  parameter int FILTERBATCH = 1
);
  import conv_pkg::*;
  localparam int N = FILTERBATCH * OUTHEIGHT * OUTWIDTH;
  logic [2*BITWIDTH*N-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic signed [BITWIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [idxW(FILTERBATCH)-1:0] out_batch;
  logic [idxW(OUTHEIGHT)-1:0] out_row;
  logic [idxW(OUTWIDTH)-1:0] out_col;
  logic out_last;
  modport master (
    output in_data, in_valid, out_ready,
    input in_ready, out_data, out_valid, out_batch, out_row, out_col, out_last
  );
  modport slave (
    input in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_batch, out_row, out_col, out_last
  );
endinterface

// File: rtl/conv_requant.sv
// conv_requant: arithmetic shift and saturation from 2*BITWIDTH to BITWIDTH bits.
// Defining CONV_RELU_EN clamps negative inputs to zero before the shift.
module conv_requant
  import conv_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int SHIFT = 4
) (
  input  logic signed [2*BITWIDTH-1:0] x,
  output logic signed [BITWIDTH-1:0] y
);
  localparam logic signed [2*BITWIDTH-1:0] MAXV = (2*BITWIDTH)'(satMax(BITWIDTH));
  localparam logic signed [2*BITWIDTH-1:0] MINV = (2*BITWIDTH)'(satMin(BITWIDTH));
  logic signed [2*BITWIDTH-1:0] xr;
  logic signed [2*BITWIDTH-1:0] sh;
`ifdef CONV_RELU_EN
  assign xr = x[2*BITWIDTH-1] ? '0 : x;
`else
  assign xr = x;
`endif
  assign sh = xr >>> SHIFT;
  assign y = sh > MAXV ? MAXV[BITWIDTH-1:0] : sh < MINV ? MINV[BITWIDTH-1:0] : sh[BITWIDTH-1:0];
endmodule

// File: rtl/conv2d_result_streamer.sv
// conv2d_result_streamer: captures a whole Conv2d output map in one handshake and streams
// requantized elements channel-major, then row, then column.
module conv2d_result_streamer
  import conv_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int OUTWIDTH = 2,
  parameter int OUTHEIGHT = 2,
  parameter int FILTERBATCH = 1,
  parameter int SHIFT = 4
) (
  input logic clk,
  input logic rst,
  conv2d_result_streamer_if.slave bus
);
  localparam int N = FILTERBATCH * OUTHEIGHT * OUTWIDTH;
  localparam int DW = 2 * BITWIDTH;
  localparam int BW = idxW(FILTERBATCH);
  localparam int RW = idxW(OUTHEIGHT);
  localparam int CW = idxW(OUTWIDTH);
  state_t stateQ, stateD;
  logic [DW*N-1:0] dataQ;
  logic [BW-1:0] bQ;
  logic [RW-1:0] rQ;
  logic [CW-1:0] cQ;
  logic cEnd, rEnd, bEnd, lastElem, streaming;
  int elemIdx;
  logic [DW-1:0] elem;
  logic signed [BITWIDTH-1:0] reqData;
  assign cEnd = cQ == CW'(OUTWIDTH - 1);
  assign rEnd = rQ == RW'(OUTHEIGHT - 1);
  assign bEnd = bQ == BW'(FILTERBATCH - 1);
  assign lastElem = bEnd && rEnd && cEnd;
  assign streaming = stateQ == STREAM;
  always_ff @(posedge clk or posedge rst)
    if (rst) stateQ <= IDLE;
    else stateQ <= stateD;
  always_comb begin
    stateD = stateQ;
    if (stateQ == IDLE) stateD = bus.in_valid ? STREAM : IDLE;
    else stateD = bus.out_ready && lastElem ? IDLE : STREAM;
  end
  // Capture only in IDLE; counters roll over to zero on the final beat.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dataQ <= '0;
      bQ <= '0;
      rQ <= '0;
      cQ <= '0;
    end else if (!streaming && bus.in_valid) begin
      dataQ <= bus.in_data;
      bQ <= '0;
      rQ <= '0;
      cQ <= '0;
    end else if (streaming && bus.out_ready) begin
      cQ <= cEnd ? '0 : cQ + 1'b1;
      rQ <= cEnd ? (rEnd ? '0 : rQ + 1'b1) : rQ;
      bQ <= cEnd && rEnd ? (bEnd ? '0 : bQ + 1'b1) : bQ;
    end
  always_comb begin
    elemIdx = (int'(bQ) * OUTHEIGHT + int'(rQ)) * OUTWIDTH + int'(cQ);
    elem = dataQ[elemIdx*DW +: DW];
  end
  conv_requant #(.BITWIDTH(BITWIDTH), .SHIFT(SHIFT)) requant (
    .x(elem),
    .y(reqData)
  );
  always_comb begin
    bus.in_ready = !streaming;
    bus.out_valid = streaming;
    bus.out_data = streaming ? reqData : '0;
    bus.out_last = streaming && lastElem;
    bus.out_batch = bQ;
    bus.out_row = rQ;
    bus.out_col = cQ;
  end
endmodule

// File: tb/tb_conv2d_result_streamer.sv
// tb_conv2d_result_streamer: directed checks on a 2x2x2 map instance and a 1x1x1 instance.
module tb_conv2d_result_streamer;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  logic [15:0] rawA [8];
  logic [15:0] rawB [8];
  logic [7:0] expA [8];
  logic [7:0] expB [8];
  logic [127:0] mapA, mapB;
  logic [15:0] pat = 16'b1011_0011_1000_1101;
  int k;
  always #5 clk = ~clk;
  conv2d_result_streamer_if #(.BITWIDTH(8), .OUTWIDTH(2), .OUTHEIGHT(2), .FILTERBATCH(2)) bus ();
  conv2d_result_streamer_if #(.BITWIDTH(8), .OUTWIDTH(1), .OUTHEIGHT(1), .FILTERBATCH(1)) bus1 ();
  conv2d_result_streamer #(.BITWIDTH(8), .OUTWIDTH(2), .OUTHEIGHT(2), .FILTERBATCH(2), .SHIFT(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  conv2d_result_streamer #(.BITWIDTH(8), .OUTWIDTH(1), .OUTHEIGHT(1), .FILTERBATCH(1), .SHIFT(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic capture(input logic [127:0] m);
    @(negedge clk);
    bus.in_data = m;
    bus.in_valid = 1;
    @(negedge clk);
    bus.in_valid = 0;
  endtask
  task automatic streamAll(input bit useB, input bit pulse);
    for (int i = 0; i < 8; i++) begin
      check("st_valid", {bus.out_valid}, 1);
      check("st_inready", {bus.in_ready}, 0);
      check("st_data", {bus.out_data}, useB ? expB[i] : expA[i]);
      check("st_idx", {bus.out_batch, bus.out_row, bus.out_col}, i);
      check("st_last", {bus.out_last}, i == 7);
      if (pulse && i == 2) begin
        bus.in_data = mapB;
        bus.in_valid = 1;
      end
      if (pulse && i == 4) bus.in_valid = 0;
      @(negedge clk);
    end
    check("end_valid", {bus.out_valid}, 0);
    check("end_inready", {bus.in_ready}, 1);
    check("end_last", {bus.out_last}, 0);
  endtask
  initial begin
    rawA = '{16'h0100, 16'h7FFF, 16'hFF00, 16'h8000, 16'h07F0, 16'h0800, 16'hF800, 16'hFFFF};
    rawB = '{16'h0050, 16'h0000, 16'hFFEF, 16'h0123, 16'h0200, 16'hFFF0, 16'h0010, 16'h7000};
`ifdef CONV_RELU_EN
    expA = '{8'h10, 8'h7F, 8'h00, 8'h00, 8'h7F, 8'h7F, 8'h00, 8'h00};
    expB = '{8'h05, 8'h00, 8'h00, 8'h12, 8'h20, 8'h00, 8'h01, 8'h7F};
`else
    expA = '{8'h10, 8'h7F, 8'hF0, 8'h80, 8'h7F, 8'h7F, 8'h80, 8'hFF};
    expB = '{8'h05, 8'h00, 8'hFE, 8'h12, 8'h20, 8'hFF, 8'h01, 8'h7F};
`endif
    for (int e = 0; e < 8; e++) begin
      mapA[e*16 +: 16] = rawA[e];
      mapB[e*16 +: 16] = rawB[e];
    end
    bus.in_data = '0;
    bus.in_valid = 0;
    bus.out_ready = 0;
    bus1.in_data = '0;
    bus1.in_valid = 0;
    bus1.out_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_inready", {bus.in_ready}, 1);
    check("rst_valid", {bus.out_valid}, 0);
    check("rst_data", {bus.out_data}, 0);
    check("rst_idx", {bus.out_batch, bus.out_row, bus.out_col}, 0);
    check("rst_last", {bus.out_last}, 0);
    check("rst1_inready", {bus1.in_ready}, 1);
    check("rst1_valid", {bus1.out_valid}, 0);
    rst = 0;
    bus.out_ready = 1;
    capture(mapA);
    streamAll(0, 1);
    bus.out_ready = 0;
    capture(mapA);
    k = 0;
    for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
      check("bp_valid", {bus.out_valid}, 1);
      check("bp_data", {bus.out_data}, expA[k]);
      check("bp_idx", {bus.out_batch, bus.out_row, bus.out_col}, k);
      check("bp_last", {bus.out_last}, k == 7);
      bus.out_ready = pat[cyc % 16];
      @(negedge clk);
      if (pat[cyc % 16]) k++;
    end
    check("bp_count", k, 8);
    check("bp_end_valid", {bus.out_valid}, 0);
    check("bp_end_inready", {bus.in_ready}, 1);
    bus.out_ready = 1;
    capture(mapA);
    check("mr_data0", {bus.out_data}, expA[0]);
    @(negedge clk);
    check("mr_data1", {bus.out_data}, expA[1]);
    @(negedge clk);
    check("mr_data2", {bus.out_data}, expA[2]);
    rst = 1;
    #1;
    check("mr_valid", {bus.out_valid}, 0);
    check("mr_inready", {bus.in_ready}, 1);
    check("mr_data", {bus.out_data}, 0);
    check("mr_idx", {bus.out_batch, bus.out_row, bus.out_col}, 0);
    check("mr_last", {bus.out_last}, 0);
    @(negedge clk);
    rst = 0;
    capture(mapB);
    streamAll(1, 0);
    bus1.out_ready = 1;
    @(negedge clk);
    bus1.in_data = 16'h0235;
    bus1.in_valid = 1;
    @(negedge clk);
    bus1.in_valid = 0;
    check("one_valid", {bus1.out_valid}, 1);
    check("one_data", {bus1.out_data}, 8'h23);
    check("one_last", {bus1.out_last}, 1);
    check("one_idx", {bus1.out_batch, bus1.out_row, bus1.out_col}, 0);
    @(negedge clk);
    check("one_end_valid", {bus1.out_valid}, 0);
    check("one_end_inready", {bus1.in_ready}, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv2d_result_streamer.md
# conv2d_result_streamer

Consumer side of the Conv2d result bus. Captures one flattened `(2*BITWIDTH)`-bit-per-element output feature map in a single handshake. Requantizes each element to `BITWIDTH` bits with an arithmetic shift and saturation, then streams the elements out one per beat under valid/ready flow control. It sits between a combinational Conv2d instance and the next layer or the output buffer.

## Interface
Parameters:
- `BITWIDTH`, 8, output element width; input elements are `2*BITWIDTH` wide, signed two's complement
- `OUTWIDTH`, 2, output feature-map width (columns)
- `OUTHEIGHT`, 2, output feature-map height (rows)
- `FILTERBATCH`, 1, number of output channels
- `SHIFT`, 4, arithmetic right shift applied before saturation; 0 ≤ SHIFT < 2*BITWIDTH

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_data`  in  `2*BITWIDTH*FILTERBATCH*OUTHEIGHT*OUTWIDTH`  flattened result bus
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  block is idle and will capture `in_data`
- `out_data`  out  `BITWIDTH`  requantized element, signed
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  downstream accepts `out_data`
- `out_batch`  out  `$clog2(FILTERBATCH)` (min 1)  channel index of the current element
- `out_row`  out  `$clog2(OUTHEIGHT)` (min 1)  row index
- `out_col`  out  `$clog2(OUTWIDTH)` (min 1)  column index
- `out_last`  out  1  current element is the final element of the map

## Operation
- Element `e = b*OUTHEIGHT*OUTWIDTH + r*OUTWIDTH + c` occupies `in_data[e*2*BITWIDTH +: 2*BITWIDTH]`.
- Elements are emitted in ascending `e` order: channel-major, then row, then column.
- States:
  - IDLE: `in_ready`=1. On `in_valid` the whole bus is registered, the counters clear, and the state goes to STREAM.
  - STREAM: `in_ready`=0. Each `out_valid && out_ready` advances `c`, wrapping into `r`, then `b`. Acceptance of the beat with `out_last` set returns to IDLE.
- `in_valid` is ignored during STREAM; no capture occurs and the held data is unchanged.
- Requantization, per element `x`:
  - `y = x >>> SHIFT` (arithmetic, rounds toward −∞).
  - If `y > 2^(BITWIDTH-1)-1`, `out_data` = `2^(BITWIDTH-1)-1`.
  - If `y < -2^(BITWIDTH-1)`, `out_data` = `-2^(BITWIDTH-1)`.
  - Otherwise `out_data` = `y[BITWIDTH-1:0]`.
- `out_last` = (`b`==FILTERBATCH-1 && `r`==OUTHEIGHT-1 && `c`==OUTWIDTH-1) && `out_valid`.
- The 1×1×1 map case is legal: the first beat carries `out_last` = 1.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_batch`/`out_row`/`out_col`=0, `out_last`=0, capture register cleared.
- Capture at edge N → `out_valid`=1 with element 0 in the cycle after edge N (latency 1).
- One element per cycle while `out_ready`=1. A full map takes `FILTERBATCH*OUTHEIGHT*OUTWIDTH` cycles after capture.
- Backpressure: while `out_valid && !out_ready`, all `out_*` outputs stay stable.
- After the last beat is accepted at edge M:
  - `out_valid`=0 and `in_ready`=1 in the cycle after M.
  - The earliest next capture is edge M+1. There is no capture-while-streaming overlap.
- `in_ready` is a registered-state decode only. It has no combinational path from `in_valid` or `out_ready`.
- `rst` asserted mid-stream: outputs return to their reset values immediately (asynchronously). The partial map is discarded and is not resumed.

## Configuration
- `CONV_RELU_EN`
  - Defined: negative `x` is forced to 0 before the shift, so `out_data` ≥ 0 always.
  - Undefined: signed requantization exactly as in Operation.
- The macro affects only the requantization datapath. Handshake and timing are identical either way.

## Structure
- Shared package `conv_pkg` holds:
  - the index-width helper (clog2 with a minimum of 1)
  - the saturation bounds as functions of `BITWIDTH`
  - the state enum `{IDLE, STREAM}`
- One sub-module, `conv_requant`: a combinational shift, optional ReLU, and saturation from `2*BITWIDTH` to `BITWIDTH`, instantiated once on the selected element.
- The top level holds the capture register, the counters, the FSM, and the element mux.

## Test plan
All values below use BITWIDTH=8, SHIFT=4 unless stated.
- Reset: assert `rst` → `in_ready`=1, `out_valid`=0, `out_data`=0, all indices 0.
- 2×2×1 map with elements {0x0100, 0x7FFF, 0xFF00, 0x8000} and `out_ready`=1:
  - Without `CONV_RELU_EN`: `out_data` = 16, 127, −16, −128 on 4 consecutive cycles; `out_last` set on beat 4 only; `in_ready`=1 on the following cycle.
  - With `CONV_RELU_EN`: the same stimulus gives 16, 127, 0, 0.
- FILTERBATCH=2, OUTHEIGHT=2, OUTWIDTH=2: (`out_batch`,`out_row`,`out_col`) steps (0,0,0) … (1,1,1) across 8 beats.
- `out_ready` toggling randomly: `out_data` and indices stay stable while stalled; no element is lost or duplicated.
- `in_valid` pulsed with different data mid-stream: the stream is unaffected.
- `rst` asserted at beat 2, then a new map is captured: the stream restarts at element 0 with the new data.
